divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/div_pkg.sv | 19 +
 rtl/sub_nbits.sv | 41 ++++
 rtl/divider_seq.sv | 135 +++++++++++++
 tb/tb_divider_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the sequential divider: default
//                operand width and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/sub_nbits.sv
`default_nettype none
// ============================================================================
//  Module      : sub_nbits
//  Description : N-bit ripple subtractor (a - b) built from propagate/generate
//                adder cells: b is inverted and the carry chain starts at 1.
//  Ports       : a, b   - operands (N bits)
//                diff   - a - b modulo 2^N
//                borrow - 1 when a < b (unsigned), i.e. NOT carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_nbits
    import div_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic w_b_inv;
        logic w_p;
        logic w_g;

        assign w_b_inv      = ~b[i];
        assign w_p          = a[i] ^ w_b_inv;
        assign w_g          = a[i] & w_b_inv;
        assign diff[i]      = w_p ^ w_carry[i];
        assign w_carry[i+1] = w_g | (w_p & w_carry[i]);
    end

    assign borrow = ~w_carry[N];

endmodule : sub_nbits
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_seq
//  Description : Sequential restoring divider, one quotient bit per cycle.
//                Signed mode works on magnitudes and fixes the signs in a
//                final cycle. Result is valid WIDTH+2 edges after start.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - request (sampled only when idle)
//                sign       - 1 = signed (DIV/REM), 0 = unsigned
//                a, b       - dividend, divisor
//                busy       - division in progress
//                done       - one-cycle pulse, q/r valid
//                q, r       - registered quotient and remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_signed;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_b_abs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic               w_unused_diff_msb;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Operand magnitudes; in unsigned mode the raw values pass through.
    assign w_a_abs = (sign & a[WIDTH-1]) ? (~a + c_ONE) : a;
    assign w_b_abs = (sign & b[WIDTH-1]) ? (~b + c_ONE) : b;

    // {rem,quo} shifted left by one: the next dividend bit enters rem.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};

    sub_nbits #(
        .N (WIDTH + 1)
    ) u_sub (
        .a      (w_shift),
        .b      ({1'b0, r_b_abs}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // A kept difference is always below |b|, so its top bit is always zero.
    assign w_unused_diff_msb = w_diff[WIDTH];

    // Divide-by-zero must leave the all-ones quotient un-negated; the
    // remainder (= |a|) is still re-signed so that r equals a.
    assign w_b_zero = (r_b_abs == '0);
    assign w_q_fix  = (r_signed & (r_neg_a ^ r_neg_b) & ~w_b_zero) ? (~r_quo + c_ONE) : r_quo;
    assign w_r_fix  = (r_signed & r_neg_a) ? (~r_rem + c_ONE) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_signed <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_abs  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_signed <= sign;
                        r_neg_a  <= sign & a[WIDTH-1];
                        r_neg_b  <= sign & b[WIDTH-1];
                        r_quo    <= w_a_abs;
                        r_b_abs  <= w_b_abs;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt + c_CNT_1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    q       <= w_q_fix;
                    r       <= w_r_fix;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : divider_seq
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_seq
//  Description : Scoreboard bench for divider_seq. The driver pushes the
//                expected quotient/remainder and completion cycle for every
//                accepted start; a monitor pops and compares on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    divider_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V style DIV/DIVU/REM/REMU semantics.
    function automatic void ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] qq, output logic [W-1:0] rr);
        if (y == '0) begin
            qq = '1;
            rr = x;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                qq = x;
                rr = '0;
            end else begin
                qq = $signed(x) / $signed(y);
                rr = $signed(x) % $signed(y);
            end
        end else begin
            qq = x / y;
            rr = x % y;
        end
    endfunction

    // Waits (bounded) for the divider to be idle, then presents one start.
    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles, required 0", busy, n);
            return;
        end
        start = 1'b1;
        sign  = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        ref_div(s, x, y, e.q, e.r);
        e.due = cyc + W + 1;
        sb.push_back(e);
        last_q = e.q;
        last_r = e.r;
        start  = 1'b0;
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        chk("done_busy_exclusive", {{(W-1){1'b0}}, done & busy}, '0);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d with no operation pending, required 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", q, e.q);
                chk("remainder", r, e.r);
                chk("latency_cycle", W'(cyc), W'(e.due));
            end
        end
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        int           n;

        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("reset_done", {{(W-1){1'b0}}, done}, '0);
        chk("reset_q", q, '0);
        chk("reset_r", r, '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios, issued back to back.
        issue(1'b0, 32'd100, 32'd7);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b0, 32'd5, 32'd0);
        issue(1'b1, 32'd5, 32'd0);
        issue(1'b1, 32'hFFFF_FFFB, 32'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b1, 32'h8000_0000, 32'd1);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);

        // A start while busy must not disturb the running division.
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        start = 1'b1;
        sign  = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset mid-operation aborts it; a start right after is accepted.
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midreset_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("midreset_done", {{(W-1){1'b0}}, done}, '0);
        chk("midreset_q", q, '0);
        chk("midreset_r", r, '0);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 32'd1000, 32'd9);

        // Randomized operands with a bias toward corner divisors.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1: begin
                    y = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) x = 32'h8000_0000;
                end
                2:       y = 32'($urandom_range(1, 15));
                3: begin
                    y = $urandom;
                    x = 32'($urandom_range(0, 20));
                end
                default: y = $urandom;
            endcase
            issue(s, x, y);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", W'(sb.size()), '0);

        repeat (5) @(posedge clk);
        #1;
        chk("q_hold", q, last_q);
        chk("r_hold", r, last_r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_divider_seq
`default_nettype wire
